pll_lpf_tuner: RTL and testbench
================================

Name: pll_lpf_tuner

Overview:
- Supervisor and tuner for the dynamic-loop-filter PLL wrapper. It drives the PLL's icpsel/lpfres/lpfcap and reset inputs, and monitors its lock output.
- It sweeps charge-pump current candidates until a stable lock is confirmed, then holds that setting. On loss of lock it relocks, and it reports readiness or failure to downstream video/audio clock consumers.
- It runs on the free-running board reference clock that also feeds the PLL.

Parameters:
- RESET_CYCLES, 16, cycles pll_reset is held high per attempt (>=1)
- LOCK_TIMEOUT, 65536, max cycles to wait for first lock assertion per candidate
- STABLE_CYCLES, 4096, consecutive lock-high cycles needed to accept a candidate
- LOSS_CYCLES, 8, consecutive lock-low cycles in LOCKED that count as lock loss
- ICP_MIN, 8, first icpsel candidate (6-bit)
- ICP_MAX, 32, last permitted icpsel candidate (6-bit)
- ICP_STEP, 4, icpsel increment between candidates (>=1)
- LPF_RES_VAL, 2, constant lpfres value (3-bit)
- LPF_CAP_VAL, 0, constant lpfcap value (2-bit)

Ports:
- clkin  in  1  reference clock
- reset  in  1  asynchronous, active-high reset
- retune  in  1  single-cycle pulse: restart the sweep from ICP_MIN
- pll_lock  in  1  PLL lock output; asynchronous to clkin
- pll_reset  out  1  PLL reset
- icpsel  out  6  PLL charge-pump select
- lpfres  out  3  PLL loop-filter resistor select
- lpfcap  out  2  PLL loop-filter capacitor select
- ready  out  1  PLL locked and confirmed stable
- tune_fail  out  1  all candidates exhausted without a stable lock
- relock_cnt  out  8  count of lock-loss events, saturating at 255

Behaviour:
- Reset values: pll_reset=1, icpsel=ICP_MIN, lpfres=LPF_RES_VAL, lpfcap=LPF_CAP_VAL, ready=0, tune_fail=0, relock_cnt=0, state=HOLD_RST, cycle counter=0.
- All outputs are registered. icpsel changes only in a cycle where pll_reset is 1. lpfres and lpfcap are constant.
- lock_s is pll_lock after the optional synchronizer; all decisions below use lock_s. The cycle counter is 24 bits.
- HOLD_RST: pll_reset=1 for exactly RESET_CYCLES cycles, then go to WAIT_LOCK with counter=0 and pll_reset=0.
- WAIT_LOCK:
  - lock_s=1: go to CONFIRM, counter=0.
  - counter reaches LOCK_TIMEOUT-1 with lock_s=0: ADVANCE.
- CONFIRM:
  - lock_s=0: ADVANCE.
  - STABLE_CYCLES consecutive lock_s=1: go to LOCKED; ready=1 from the next cycle.
- LOCKED:
  - ready=1. The counter counts consecutive lock_s=0 and clears on lock_s=1.
  - LOSS_CYCLES consecutive lows: ready=0, relock_cnt+=1 (saturating at 255), go to HOLD_RST with the same icpsel.
  - Glitches shorter than LOSS_CYCLES are ignored.
- ADVANCE (a same-cycle transition, not a state):
  - Next candidate = icpsel+ICP_STEP, computed 7 bits wide so it cannot wrap.
  - If the sum is <= ICP_MAX: icpsel=sum, go to HOLD_RST.
  - Otherwise go to FAIL.
- FAIL: tune_fail=1, pll_reset=1 (PLL held in reset), icpsel unchanged. Stays here until retune or reset.
- retune=1 in any state, highest priority:
  - Next cycle: HOLD_RST, counter=0, icpsel=ICP_MIN, ready=0, tune_fail=0.
  - relock_cnt is preserved.
  - retune held high restarts every cycle; the sweep begins after it deasserts.
- reset mid-operation: immediately returns every output to its reset value.
- ICP_MIN > ICP_MAX: the first ADVANCE goes to FAIL. ICP_MIN itself is still tried once.

Optional Feature:
- Macro: PLL_TUNE_LOCK_SYNC_EN.
- Defined: pll_lock passes through a 2-flop synchronizer, reset to 0. lock_s lags pll_lock by 2 cycles, and every lock-related timing above shifts by 2 cycles.
- Undefined: lock_s=pll_lock directly. For use only when the lock source is already synchronous to clkin.

Test Plan (bench params: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, LOSS_CYCLES=3, ICP_MIN=8, ICP_MAX=16, ICP_STEP=4, macro undefined):
- Reset release, model locks 5 cycles after pll_reset falls and stays locked -> pll_reset high 4 cycles, icpsel=8, ready rises 8 cycles after lock, tune_fail=0.
- Model never locks -> icpsel goes 8, 12, 16, each attempt = 4 reset + 20 wait cycles; then tune_fail=1, pll_reset=1, icpsel=16, ready=0.
- Lock only at icpsel=12; at icpsel=8 lock pulses high 5 cycles then drops -> the drop advances to 12; ready=1 with icpsel=12.
- In LOCKED, lock drops for 2 cycles -> ready stays 1, relock_cnt=0.
- In LOCKED, lock drops for 3 cycles -> ready=0, relock_cnt=1, pll_reset pulses 4 cycles, icpsel unchanged, relock completes.
- retune pulse while in FAIL, and again mid-CONFIRM -> next cycle HOLD_RST, icpsel=8, tune_fail=0; assert reset mid-WAIT_LOCK -> all outputs at reset values.

Source files
------------

// File: rtl/pll_lpf_tuner.sv
// pll_lpf_tuner: supervisor and charge-pump tuner for the dynamic-loop-filter PLL.
//   Sweeps icpsel from ICP_MIN in ICP_STEP increments until a stable lock is confirmed,
//   then holds the setting, relocks on lock loss, and reports ready or tune_fail.
// Ports:
//   clkin, reset          free-running reference clock, asynchronous active-high reset
//   retune                single-cycle pulse, restarts the sweep from ICP_MIN
//   pll_lock              PLL lock indication (asynchronous unless already synchronous)
//   pll_reset, icpsel,    PLL control outputs; lpfres/lpfcap are constant values
//   lpfres, lpfcap
//   ready, tune_fail,     status: stable lock, sweep exhausted, saturating lock-loss count
//   relock_cnt
// Optional macro PLL_TUNE_LOCK_SYNC_EN: pll_lock passes through a 2-flop synchronizer
//   (lock decisions then lag pll_lock by 2 cycles); without it pll_lock is used directly.
module pll_lpf_tuner #(
   parameter int unsigned RESET_CYCLES  = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned STABLE_CYCLES = 4096,
   parameter int unsigned LOSS_CYCLES   = 8,
   parameter int unsigned ICP_MIN       = 8,
   parameter int unsigned ICP_MAX       = 32,
   parameter int unsigned ICP_STEP      = 4,
   parameter logic [2:0]  LPF_RES_VAL   = 3'd2,
   parameter logic [1:0]  LPF_CAP_VAL   = 2'd0
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       retune,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] icpsel,
   output logic [2:0] lpfres,
   output logic [1:0] lpfcap,
   output logic       ready,
   output logic       tune_fail,
   output logic [7:0] relock_cnt
);

   localparam logic [23:0] RST_LAST    = 24'(RESET_CYCLES - 1);
   localparam logic [23:0] TO_LAST     = 24'(LOCK_TIMEOUT - 1);
   localparam logic [23:0] STABLE_LAST = 24'(STABLE_CYCLES - 1);
   localparam logic [23:0] LOSS_LAST   = 24'(LOSS_CYCLES - 1);
   localparam logic [5:0]  ICP_FIRST   = 6'(ICP_MIN);
   localparam logic [6:0]  ICP_LAST    = 7'(ICP_MAX);
   localparam logic [6:0]  ICP_INC     = 7'(ICP_STEP);

   typedef enum logic [2:0] {
      S_HOLD_RST,
      S_WAIT_LOCK,
      S_CONFIRM,
      S_LOCKED,
      S_FAIL
   } state_t;

   state_t      state, state_nxt;
   logic [23:0] cnt, cnt_nxt;
   logic [5:0]  icp_nxt;
   logic        pll_reset_nxt;
   logic        ready_nxt;
   logic        fail_nxt;
   logic [7:0]  relock_nxt;
   logic [6:0]  icp_sum;
   logic        advance;
   logic        lock_s;

`ifdef PLL_TUNE_LOCK_SYNC_EN
   logic [1:0] lock_sync;

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         lock_sync <= 2'b00;
      end else begin
         lock_sync <= {lock_sync[0], pll_lock};
      end
   end

   assign lock_s = lock_sync[1];
`else
   assign lock_s = pll_lock;
`endif

   // Computed one bit wider than icpsel so a large step cannot wrap back into range.
   assign icp_sum = {1'b0, icpsel} + ICP_INC;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      icp_nxt       = icpsel;
      pll_reset_nxt = pll_reset;
      ready_nxt     = ready;
      fail_nxt      = tune_fail;
      relock_nxt    = relock_cnt;
      advance       = 1'b0;

      if (retune) begin
         state_nxt     = S_HOLD_RST;
         cnt_nxt       = '0;
         icp_nxt       = ICP_FIRST;
         pll_reset_nxt = 1'b1;
         ready_nxt     = 1'b0;
         fail_nxt      = 1'b0;
      end else begin
         case (state)
            S_HOLD_RST: begin
               pll_reset_nxt = 1'b1;
               if (cnt == RST_LAST) begin
                  state_nxt     = S_WAIT_LOCK;
                  cnt_nxt       = '0;
                  pll_reset_nxt = 1'b0;
               end else begin
                  cnt_nxt = cnt + 24'd1;
               end
            end
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = S_CONFIRM;
                  cnt_nxt   = '0;
               end else if (cnt == TO_LAST) begin
                  advance = 1'b1;
               end else begin
                  cnt_nxt = cnt + 24'd1;
               end
            end
            S_CONFIRM: begin
               // Any drop during confirmation rejects this candidate outright.
               if (!lock_s) begin
                  advance = 1'b1;
               end else if (cnt == STABLE_LAST) begin
                  state_nxt = S_LOCKED;
                  cnt_nxt   = '0;
                  ready_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + 24'd1;
               end
            end
            S_LOCKED: begin
               // Counter tracks consecutive lows only; short glitches are forgiven.
               if (lock_s) begin
                  cnt_nxt = '0;
               end else if (cnt == LOSS_LAST) begin
                  state_nxt     = S_HOLD_RST;
                  cnt_nxt       = '0;
                  pll_reset_nxt = 1'b1;
                  ready_nxt     = 1'b0;
                  if (relock_cnt != 8'hFF) begin
                     relock_nxt = relock_cnt + 8'd1;
                  end
               end else begin
                  cnt_nxt = cnt + 24'd1;
               end
            end
            S_FAIL: begin
               pll_reset_nxt = 1'b1;
               fail_nxt      = 1'b1;
            end
            default: begin
               state_nxt     = S_HOLD_RST;
               cnt_nxt       = '0;
               pll_reset_nxt = 1'b1;
            end
         endcase

         // Candidate rejected: the new icpsel is registered together with pll_reset=1,
         // so the charge-pump setting never changes while the PLL is running.
         if (advance) begin
            cnt_nxt       = '0;
            pll_reset_nxt = 1'b1;
            if (icp_sum <= ICP_LAST) begin
               state_nxt = S_HOLD_RST;
               icp_nxt   = icp_sum[5:0];
            end else begin
               state_nxt = S_FAIL;
               fail_nxt  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state      <= S_HOLD_RST;
         cnt        <= '0;
         pll_reset  <= 1'b1;
         icpsel     <= ICP_FIRST;
         lpfres     <= LPF_RES_VAL;
         lpfcap     <= LPF_CAP_VAL;
         ready      <= 1'b0;
         tune_fail  <= 1'b0;
         relock_cnt <= 8'd0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         pll_reset  <= pll_reset_nxt;
         icpsel     <= icp_nxt;
         lpfres     <= LPF_RES_VAL;
         lpfcap     <= LPF_CAP_VAL;
         ready      <= ready_nxt;
         tune_fail  <= fail_nxt;
         relock_cnt <= relock_nxt;
      end
   end

endmodule

// File: tb/tb_pll_lpf_tuner.sv
// tb_pll_lpf_tuner: bench for pll_lpf_tuner with a behavioural PLL lock model.
//   Expected output-change events are predicted per tuning attempt and queued;
//   a monitor compares every observed output change against the queue.
module tb_pll_lpf_tuner;

   localparam int R     = 4;
   localparam int TO    = 20;
   localparam int S     = 8;
   localparam int LOSS  = 3;
   localparam int IMIN  = 8;
   localparam int IMAX  = 16;
   localparam int ISTEP = 4;

   localparam int NEVER = 0;
   localparam int PULSE = 1;
   localparam int GOOD  = 2;

   logic       clkin = 1'b0;
   logic       reset = 1'b0;
   logic       retune = 1'b0;
   logic       pll_lock = 1'b0;
   logic       pll_reset;
   logic [5:0] icpsel;
   logic [2:0] lpfres;
   logic [1:0] lpfcap;
   logic       ready;
   logic       tune_fail;
   logic [7:0] relock_cnt;

   typedef struct {
      int         t;
      logic       rst;
      logic [5:0] icp;
      logic       rdy;
      logic       fail;
      logic [7:0] rel;
   } ev_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   ev_t  exp_q[$];
   ev_t  exp_last, m_last, last_obs, mon_cur, mon_e;
   bit   mon_en = 1'b0;

   // PLL behaviour per icpsel value: kind, lock delay after reset release, pulse width.
   int   kind [64];
   int   dly  [64];
   int   pw   [64];
   int   glitch_left = 0;
   int   lowcnt = 0;

   int   m_rel = 0;
   bit   m_locked = 1'b0;
   int   m_icp = IMIN;
   int   m_L = 0;

   pll_lpf_tuner #(
      .RESET_CYCLES (R),
      .LOCK_TIMEOUT (TO),
      .STABLE_CYCLES(S),
      .LOSS_CYCLES  (LOSS),
      .ICP_MIN      (IMIN),
      .ICP_MAX      (IMAX),
      .ICP_STEP     (ISTEP),
      .LPF_RES_VAL  (3'd2),
      .LPF_CAP_VAL  (2'd0)
   ) dut (
      .clkin     (clkin),
      .reset     (reset),
      .retune    (retune),
      .pll_lock  (pll_lock),
      .pll_reset (pll_reset),
      .icpsel    (icpsel),
      .lpfres    (lpfres),
      .lpfcap    (lpfcap),
      .ready     (ready),
      .tune_fail (tune_fail),
      .relock_cnt(relock_cnt)
   );

   initial forever #5 clkin = ~clkin;

   initial forever begin
      @(posedge clkin);
      cyc++;
   end

   // PLL model: lock follows the configured behaviour, counted from pll_reset falling.
   initial forever begin
      @(negedge clkin);
      if (pll_reset !== 1'b0) begin
         lowcnt   = 0;
         pll_lock = 1'b0;
      end else begin
         lowcnt++;
         if (kind[icpsel] == GOOD)
            pll_lock = (lowcnt >= dly[icpsel]);
         else if (kind[icpsel] == PULSE)
            pll_lock = (lowcnt >= dly[icpsel]) && (lowcnt < dly[icpsel] + pw[icpsel]);
         else
            pll_lock = 1'b0;
      end
      if (glitch_left > 0) begin
         pll_lock = 1'b0;
         glitch_left--;
      end
   end

   function automatic bit same(input ev_t a, input ev_t b);
      return (a.rst === b.rst) && (a.icp === b.icp) && (a.rdy === b.rdy) &&
             (a.fail === b.fail) && (a.rel === b.rel);
   endfunction

   // Monitor: every change of the output tuple must match the next expected event.
   initial forever begin
      @(negedge clkin);
      if (mon_en) begin
         mon_cur.t    = cyc;
         mon_cur.rst  = pll_reset;
         mon_cur.icp  = icpsel;
         mon_cur.rdy  = ready;
         mon_cur.fail = tune_fail;
         mon_cur.rel  = relock_cnt;
         if (!same(mon_cur, last_obs)) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change cyc=%0d got rst=%b icp=%0d rdy=%b fail=%b rel=%0d",
                        cyc, mon_cur.rst, mon_cur.icp, mon_cur.rdy, mon_cur.fail, mon_cur.rel);
            end else begin
               mon_e = exp_q.pop_front();
               if (!same(mon_cur, mon_e) || mon_cur.t != mon_e.t) begin
                  failures++;
                  $display("FAIL event got cyc=%0d rst=%b icp=%0d rdy=%b fail=%b rel=%0d expected cyc=%0d rst=%b icp=%0d rdy=%b fail=%b rel=%0d",
                           mon_cur.t, mon_cur.rst, mon_cur.icp, mon_cur.rdy, mon_cur.fail, mon_cur.rel,
                           mon_e.t, mon_e.rst, mon_e.icp, mon_e.rdy, mon_e.fail, mon_e.rel);
               end
               exp_last = mon_e;
            end
            last_obs = mon_cur;
         end
      end
   end

   task automatic m_push(input int t, input logic rst, input logic [5:0] icp,
                         input logic rdy, input logic fl);
      ev_t e;
      e.t = t; e.rst = rst; e.icp = icp; e.rdy = rdy; e.fail = fl; e.rel = 8'(m_rel);
      if (!same(e, m_last)) begin
         exp_q.push_back(e);
         m_last = e;
      end
   endtask

   // Reference model: one tuning sweep starting with pll_reset=1 after cycle t0.
   // Each attempt: R reset cycles, up to TO wait cycles, then S confirm cycles.
   task automatic predict_sweep(input int t0, input int icp0);
      int t, icp, f, a;
      bit done;
      t = t0; icp = icp0; done = 1'b0; m_locked = 1'b0;
      while (!done) begin
         f = t + R;
         m_push(f, 1'b0, 6'(icp), 1'b0, 1'b0);
         if (kind[icp] != NEVER && dly[icp] <= TO) begin
            m_L = f + dly[icp];
            if (kind[icp] == GOOD) begin
               m_push(m_L + S, 1'b0, 6'(icp), 1'b1, 1'b0);
               m_locked = 1'b1;
               m_icp = icp;
               done = 1'b1;
            end
            a = m_L + pw[icp];
         end else begin
            a = f + TO;
         end
         if (!done) begin
            if (icp + ISTEP <= IMAX) begin
               icp = icp + ISTEP;
               m_push(a, 1'b1, 6'(icp), 1'b0, 1'b0);
               t = a;
            end else begin
               m_push(a, 1'b1, 6'(icp), 1'b0, 1'b1);
               m_icp = icp;
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clkin);
      #1;
   endtask

   task automatic settle(input int n);
      repeat (n) step();
   endtask

   task automatic at_cycle(input int tc);
      @(negedge clkin);
      while (cyc < tc) @(negedge clkin);
      #1;
   endtask

   task automatic check_state(input string name, input logic rst, input logic [5:0] icp,
                              input logic rdy, input logic fl, input logic [7:0] rel);
      checks++;
      if (pll_reset !== rst || icpsel !== icp || ready !== rdy || tune_fail !== fl ||
          relock_cnt !== rel || lpfres !== 3'd2 || lpfcap !== 2'd0) begin
         failures++;
         $display("FAIL %s got rst=%b icp=%0d rdy=%b fail=%b rel=%0d res=%0d cap=%0d expected rst=%b icp=%0d rdy=%b fail=%b rel=%0d res=2 cap=0",
                  name, pll_reset, icpsel, ready, tune_fail, relock_cnt, lpfres, lpfcap,
                  rst, icp, rdy, fl, rel);
      end
   endtask

   task automatic check_final(input string name);
      check_state(name, exp_last.rst, exp_last.icp, exp_last.rdy, exp_last.fail, exp_last.rel);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clkin);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s timeout pending=%0d next_expected_cyc=%0d now=%0d",
                  name, exp_q.size(), exp_q[0].t, cyc);
         exp_q.delete();
      end
   endtask

   task automatic do_reset(input string name);
      step();
      reset = 1'b1;
      mon_en = 1'b0;
      exp_q.delete();
      #1;
      check_state({name, "_async"}, 1'b1, 6'(IMIN), 1'b0, 1'b0, 8'd0);
      step();
      step();
      check_state({name, "_held"}, 1'b1, 6'(IMIN), 1'b0, 1'b0, 8'd0);
      m_rel = 0;
      exp_last.t = cyc; exp_last.rst = 1'b1; exp_last.icp = 6'(IMIN);
      exp_last.rdy = 1'b0; exp_last.fail = 1'b0; exp_last.rel = 8'd0;
      m_last = exp_last;
      last_obs = exp_last;
      reset = 1'b0;
      mon_en = 1'b1;
      predict_sweep(cyc, IMIN);
   endtask

   // Caller is positioned just after a falling edge; retune is sampled at the next rising edge.
   task automatic do_retune();
      retune = 1'b1;
      exp_q.delete();
      m_last = exp_last;
      m_push(cyc + 1, 1'b1, 6'(IMIN), 1'b0, 1'b0);
      predict_sweep(cyc + 1, IMIN);
      step();
      retune = 1'b0;
   endtask

   // Forces lock low for k cycles while LOCKED; LOSS or more lows is a lock-loss event.
   task automatic do_glitch(input int k);
      step();
      glitch_left = k;
      if (k >= LOSS) begin
         m_rel = (m_rel < 255) ? m_rel + 1 : 255;
         m_push(cyc + 1 + LOSS, 1'b1, 6'(m_icp), 1'b0, 1'b0);
         predict_sweep(cyc + 1 + LOSS, m_icp);
      end
   endtask

   task automatic set_never();
      for (int i = 0; i < 64; i++) begin
         kind[i] = NEVER;
         dly[i]  = 1;
         pw[i]   = 1;
      end
   endtask

   initial begin
      set_never();
      #2 reset = 1'b1;

      // Locks 5 cycles after reset release at the first candidate.
      kind[8] = GOOD; dly[8] = 5;
      do_reset("t1_reset");
      drain("t1_drain", 200);
      settle(6);
      check_state("t1_locked", 1'b0, 6'd8, 1'b1, 1'b0, 8'd0);

      // Short glitch is ignored.
      do_glitch(2);
      settle(10);
      check_state("glitch2_ignored", 1'b0, 6'd8, 1'b1, 1'b0, 8'd0);

      // Glitch of LOSS cycles forces a relock with the same icpsel.
      do_glitch(3);
      drain("relock_drain", 200);
      settle(4);
      check_state("relock_done", 1'b0, 6'd8, 1'b1, 1'b0, 8'd1);

      // Never locks: sweep 8,12,16 then fail.
      set_never();
      do_reset("t2_reset");
      drain("t2_drain", 300);
      settle(6);
      check_state("t2_fail", 1'b1, 6'd16, 1'b0, 1'b1, 8'd0);

      // Retune from FAIL, then retune again in the middle of confirmation.
      kind[8] = GOOD; dly[8] = 3;
      step();
      do_retune();
      at_cycle(m_L + 3);
      do_retune();
      drain("retune_drain", 300);
      settle(4);
      check_state("retune_relocked", 1'b0, 6'd8, 1'b1, 1'b0, 8'd0);

      // Pulse at 8 drops mid-confirm, good lock at 12.
      set_never();
      kind[8] = PULSE; dly[8] = 2; pw[8] = 5;
      kind[12] = GOOD; dly[12] = 3;
      do_reset("t3_reset");
      drain("t3_drain", 300);
      settle(4);
      check_state("t3_locked12", 1'b0, 6'd12, 1'b1, 1'b0, 8'd0);

      // Reset asserted mid-WAIT_LOCK.
      set_never();
      do_reset("t6_reset");
      at_cycle(cyc + R + 6);
      do_reset("midwait_reset");
      drain("midwait_drain", 300);
      settle(4);
      check_final("midwait_fail");

      // Randomized PLL behaviour per candidate, including boundary lock delays.
      for (int it = 0; it < 12; it++) begin
         set_never();
         for (int c = IMIN; c <= IMAX; c += ISTEP) begin
            kind[c] = int'($urandom_range(0, 2));
            dly[c]  = int'($urandom_range(1, TO + 1));
            pw[c]   = int'($urandom_range(1, S));
         end
         do_reset("rand_reset");
         drain("rand_drain", 400);
         settle(4);
         check_final("rand_sweep");
         if (m_locked) begin
            do_glitch(int'($urandom_range(1, 4)));
            drain("rand_glitch_drain", 300);
            settle(6);
            check_final("rand_glitch");
         end
         if ($urandom_range(0, 1) == 1) begin
            do_retune();
            drain("rand_retune_drain", 400);
            settle(4);
            check_final("rand_retune");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
